// File: rtl/aes_round_iter.sv
// Iterated AES-style round engine: one registered round cell reused N times per job.
// Latency: result valid exactly N+1 clock edges after the accepting edge (N = clamped round count).
// Backpressure: one job in flight; in_ready only in IDLE, result held stable until out_ready.

// one_round: r_o <= MixColumns(ShiftRows(SubBytes(key_i))) ^ state_i.
// key_i carries the evolving data, state_i a fixed operand; output register is not reset.
module one_round (
  input  logic         clk,
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] r_o
);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, and 255-b == ~b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0]   sb [16];
  logic [7:0]   mc [16];
  logic [127:0] nxt;
  logic [127:0] r_q;

  // Column-major byte order: byte i = bits [127-8i -: 8], row = i%4, column = i/4.
  always_comb begin
    nxt = '0;
    // SubBytes fused with ShiftRows: row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[4*c+r] = sbox(key_i[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    // MixColumns on each column.
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sb[4*c]) ^ xtime(sb[4*c+1]) ^ sb[4*c+1] ^ sb[4*c+2] ^ sb[4*c+3];
      mc[4*c+1] = sb[4*c] ^ xtime(sb[4*c+1]) ^ xtime(sb[4*c+2]) ^ sb[4*c+2] ^ sb[4*c+3];
      mc[4*c+2] = sb[4*c] ^ sb[4*c+1] ^ xtime(sb[4*c+2]) ^ xtime(sb[4*c+3]) ^ sb[4*c+3];
      mc[4*c+3] = xtime(sb[4*c]) ^ sb[4*c] ^ sb[4*c+1] ^ sb[4*c+2] ^ xtime(sb[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      nxt[127-8*i -: 8] = mc[i] ^ state_i[127-8*i -: 8];
    end
  end

  // Round output register; upstream mux makes its reset value irrelevant.
  always_ff @(posedge clk) begin
    r_q <= nxt;
  end

  assign r_o = r_q;

endmodule

module aes_round_iter #(
  parameter int             MAX_ROUNDS = 35,
  parameter int             CW         = 6,
  parameter logic [127:0]   WHITEN     = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  key,
  input  logic [CW-1:0] rounds,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out,
  output logic          busy,
  output logic [CW-1:0] rnd_cnt,
  output logic          clamped
);

  localparam logic [CW-1:0] MAX_N = CW'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  src_q, src_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          clamped_q, clamped_d;

  logic [127:0]  round_r;
  logic [127:0]  key_op;
  logic          accept;
  logic          over;

  // First round consumes the whitened key, later rounds feed back the cell output.
  assign key_op = (cnt_q == '0) ? src_q : round_r;

  one_round u_round (
    .clk     (clk),
    .state_i (WHITEN),
    .key_i   (key_op),
    .r_o     (round_r)
  );

  assign accept = in_valid && (state_q == S_IDLE);
  assign over   = (rounds > MAX_N);

  // Next-state and datapath updates for the IDLE/RUN/HOLD job sequencer.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    clamped_d = clamped_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          src_d     = key ^ WHITEN;
          n_d       = over ? MAX_N : rounds;
          clamped_d = over;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == n_q) begin
          // A zero-round job returns the whitened key untouched.
          out_d     = (n_q == '0) ? src_q : round_r;
          out_vld_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset wins over accept and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      clamped_q <= clamped_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_vld_q;
  assign out       = out_q;
  assign rnd_cnt   = cnt_q;
  assign clamped   = clamped_q;

endmodule
